// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
//   Hard-wired control unit for a single-bus datapath. Each instruction is
//   sequenced as T0..T5 (T6 for MUL/DIV). A T1W wait state is inserted while
//   memory has not yet delivered the instruction word. The datapath controls
//   are decoded from the state register and the IR contents, so an
//   asynchronous reset clears them immediately.
//
// Parameters
//   CNT_W        width of the retired-instruction counter (wraps)
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   run          level; high = fetch/execute continuously
//   step         (only with ALU_SEQ_STEP_EN) starts one instruction per pulse
//   mem_ready    memory read data valid this cycle
//   ir           IR register contents (meaningful from T3 onward)
//   pc_out .. hi_in   single-bit datapath controls
//   gpr_in       one-hot GPR load enable
//   gpr_out      one-hot GPR bus drive
//   alu_op       ALU opcode (AND=0 OR=1 ADD=2 SUB=3 SHR=4 SHL=5 ROR=6 ROL=7
//                MUL=8 DIV=9 NEG=10 NOT=11)
//   instr_done   one-cycle pulse in the final T-state of every instruction
//   illegal      sticky flag, an unsupported opcode was decoded
//   instr_count  number of retired instructions
//
// Configuration
//   ALU_SEQ_STEP_EN  when defined, adds the step input. Starting a new
//                    instruction then also needs step=1 in that cycle.
// -----------------------------------------------------------------------------
module alu_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
`ifdef ALU_SEQ_STEP_EN
    input  logic             step,
`endif
    input  logic             mem_ready,
    input  logic [31:0]      ir,
    output logic             pc_out,
    output logic             mar_in,
    output logic             inc_pc,
    output logic             pc_in,
    output logic             read,
    output logic             mdr_in,
    output logic             mdr_out,
    output logic             ir_in,
    output logic             y_in,
    output logic             z_in,
    output logic             z_low_out,
    output logic             z_high_out,
    output logic             lo_in,
    output logic             hi_in,
    output logic [15:0]      gpr_in,
    output logic [15:0]      gpr_out,
    output logic [3:0]       alu_op,
    output logic             instr_done,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_T0    = 4'd1,
        S_T1    = 4'd2,
        S_T1W   = 4'd3,
        S_T2    = 4'd4,
        S_T3    = 4'd5,
        S_T4    = 4'd6,
        S_T5    = 4'd7,
        S_T6    = 4'd8,
        S_FAULT = 4'd9
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'd2;

    state_t           state_q, state_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [4:0]  opc_s;
    logic [3:0]  ra_s, rb_s, rc_s;
    logic        legal_s, muldiv_s, unary_s, go_s;
    logic        done_s;
    logic        ir_unused_s;

    // Register index to one-hot GPR select.
    function automatic logic [15:0] onehot16(input logic [3:0] idx);
        onehot16 = 16'd1 << idx;
    endfunction

    assign opc_s       = ir[31:27];
    assign ra_s        = ir[26:23];
    assign rb_s        = ir[22:19];
    assign rc_s        = ir[18:15];
    assign legal_s     = (opc_s <= 5'd11);
    assign muldiv_s    = (opc_s == 5'd8) || (opc_s == 5'd9);
    assign unary_s     = (opc_s == 5'd10) || (opc_s == 5'd11);
    assign ir_unused_s = ^ir[14:0];

`ifdef ALU_SEQ_STEP_EN
    assign go_s = run & step;
`else
    assign go_s = run;
`endif

    // Next-state, sticky illegal flag and retired-instruction counter.
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        count_d   = count_q;
        case (state_q)
            S_IDLE: begin
                if (go_s) state_d = S_T0;
                else      state_d = S_IDLE;
            end
            S_T0:   state_d = S_T1;
            S_T1, S_T1W: begin
                if (mem_ready) state_d = S_T2;
                else           state_d = S_T1W;
            end
            S_T2:   state_d = S_T3;
            S_T3: begin
                if (legal_s) begin
                    state_d = S_T4;
                end else begin
                    state_d   = S_FAULT;
                    illegal_d = 1'b1;
                end
            end
            S_T4:   state_d = S_T5;
            S_T5: begin
                if (muldiv_s)  state_d = S_T6;
                else if (go_s) state_d = S_T0;
                else           state_d = S_IDLE;
            end
            S_T6: begin
                if (go_s) state_d = S_T0;
                else      state_d = S_IDLE;
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase
        if (done_s) count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        else        count_d = count_q;
    end

    // State, illegal flag and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            illegal_q <= 1'b0;
            count_q   <= {CNT_W{1'b0}};
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            count_q   <= count_d;
        end
    end

    // Control decode from the state register and IR; at most one bus driver per state.
    always_comb begin
        pc_out     = 1'b0;
        mar_in     = 1'b0;
        inc_pc     = 1'b0;
        pc_in      = 1'b0;
        read       = 1'b0;
        mdr_in     = 1'b0;
        mdr_out    = 1'b0;
        ir_in      = 1'b0;
        y_in       = 1'b0;
        z_in       = 1'b0;
        z_low_out  = 1'b0;
        z_high_out = 1'b0;
        lo_in      = 1'b0;
        hi_in      = 1'b0;
        gpr_in     = 16'd0;
        gpr_out    = 16'd0;
        alu_op     = ALU_ADD;
        done_s     = 1'b0;
        case (state_q)
            S_IDLE, S_FAULT: alu_op = 4'd0;
            S_T0: begin
                pc_out = 1'b1;
                mar_in = 1'b1;
                inc_pc = 1'b1;
                z_in   = 1'b1;
            end
            S_T1: begin
                z_low_out = 1'b1;
                pc_in     = 1'b1;
                read      = 1'b1;
                mdr_in    = 1'b1;
            end
            // PC was already reloaded in T1; only keep the read going.
            S_T1W: begin
                read   = 1'b1;
                mdr_in = 1'b1;
            end
            S_T2: begin
                mdr_out = 1'b1;
                ir_in   = 1'b1;
            end
            S_T3: begin
                if (legal_s) begin
                    gpr_out = onehot16(rb_s);
                    y_in    = 1'b1;
                end else begin
                    gpr_out = 16'd0;
                    y_in    = 1'b0;
                end
            end
            // Unary ops re-drive rb; Y holds a don't-care operand.
            S_T4: begin
                if (unary_s) gpr_out = onehot16(rb_s);
                else         gpr_out = onehot16(rc_s);
                alu_op = opc_s[3:0];
                z_in   = 1'b1;
            end
            S_T5: begin
                z_low_out = 1'b1;
                if (muldiv_s) begin
                    lo_in = 1'b1;
                end else begin
                    gpr_in = onehot16(ra_s);
                    done_s = 1'b1;
                end
            end
            S_T6: begin
                z_high_out = 1'b1;
                hi_in      = 1'b1;
                done_s     = 1'b1;
            end
            default: alu_op = 4'd0;
        endcase
    end

    assign instr_done  = done_s;
    assign illegal     = illegal_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_sequencer
//   Scoreboard bench for alu_sequencer (CNT_W=4 so wrap-around is reachable).
//   The driver issues instructions and pushes the expected per-instruction
//   behaviour (operand selects, ALU op, write target, latency, wait count,
//   counter value); an independent monitor reconstructs each instruction
//   from the control outputs and compares at instr_done.
// -----------------------------------------------------------------------------
module tb_alu_sequencer;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset, run, mem_ready, step;
    logic [31:0]   ir;
    logic          pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in;
    logic          y_in, z_in, z_low_out, z_high_out, lo_in, hi_in;
    logic [15:0]   gpr_in, gpr_out;
    logic [3:0]    alu_op;
    logic          instr_done, illegal;
    logic [CW-1:0] instr_count;
    logic [50:0]   ctl;

    typedef struct {
        logic [15:0] rd1;
        logic [15:0] rd2;
        logic [15:0] wr;
        logic [3:0]  op;
        logic        lo;
        logic        hi;
        int          cycles;
        int          waits;
        logic [3:0]  cnt;
    } exp_t;

    exp_t       sb[$];
    int         tests = 0;
    int         fails = 0;
    logic [3:0] exp_count = 4'd0;

    always #5 clk = ~clk;

    assign ctl = {pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in,
                  y_in, z_in, z_low_out, z_high_out, lo_in, hi_in,
                  gpr_in, gpr_out, alu_op, instr_done};

    alu_sequencer #(.CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .run(run),
`ifdef ALU_SEQ_STEP_EN
        .step(step),
`endif
        .mem_ready(mem_ready), .ir(ir),
        .pc_out(pc_out), .mar_in(mar_in), .inc_pc(inc_pc), .pc_in(pc_in),
        .read(read), .mdr_in(mdr_in), .mdr_out(mdr_out), .ir_in(ir_in),
        .y_in(y_in), .z_in(z_in), .z_low_out(z_low_out), .z_high_out(z_high_out),
        .lo_in(lo_in), .hi_in(hi_in), .gpr_in(gpr_in), .gpr_out(gpr_out),
        .alu_op(alu_op), .instr_done(instr_done), .illegal(illegal),
        .instr_count(instr_count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit oh0(input logic [15:0] v);
        return (v & (v - 16'd1)) == 16'd0;
    endfunction

    // ---------------- monitor ----------------
    initial begin : monitor
        logic in_i, chk_b2b, pend, bad, lo, hi;
        logic [3:0]  pend_v, op;
        logic [15:0] rd1, rd2, wr;
        int cyc, waits, nrd, ndrv;
        exp_t e;
        in_i = 1'b0; chk_b2b = 1'b0; pend = 1'b0; bad = 1'b0; lo = 1'b0; hi = 1'b0;
        pend_v = 4'd0; op = 4'd0; rd1 = 16'd0; rd2 = 16'd0; wr = 16'd0;
        cyc = 0; waits = 0; nrd = 0;
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                in_i = 1'b0; chk_b2b = 1'b0; pend = 1'b0;
            end else begin
                if (pend) begin
                    check("count", 64'(instr_count), 64'(pend_v));
                    pend = 1'b0;
                end
                if (chk_b2b) begin
                    check("b2b_t0", 64'(pc_out), 64'd1);
                    chk_b2b = 1'b0;
                end
                if (pc_out) begin
                    check("t0_alu_add", 64'(alu_op), 64'd2);
                    check("t0_ctl", 64'({mar_in, inc_pc, z_in}), 64'd7);
                    in_i = 1'b1; cyc = 0; waits = 0; nrd = 0;
                    rd1 = 16'd0; rd2 = 16'd0; wr = 16'd0; op = 4'd0;
                    lo = 1'b0; hi = 1'b0; bad = 1'b0;
                end
                if (in_i) begin
                    cyc++;
                    if (read && !pc_in) waits++;
                    if (gpr_out != 16'd0) begin
                        if (nrd == 0) rd1 = gpr_out;
                        else if (nrd == 1) begin rd2 = gpr_out; op = alu_op; end
                        nrd++;
                    end
                    wr = wr | gpr_in;
                    lo = lo | lo_in;
                    hi = hi | hi_in;
                    ndrv = int'(pc_out) + int'(z_low_out) + int'(z_high_out) +
                           int'(mdr_out) + int'(gpr_out != 16'd0);
                    if (ndrv > 1 || !oh0(gpr_out) || !oh0(gpr_in)) bad = 1'b1;
                    if (instr_done) begin
                        if (sb.size() == 0) begin
                            tests++; fails++;
                            $display("FAIL unexpected_done: instr_done with empty scoreboard");
                        end else begin
                            e = sb.pop_front();
                            check("rb_drive", 64'(rd1), 64'(e.rd1));
                            check("second_drive", 64'(rd2), 64'(e.rd2));
                            check("alu_op", 64'(op), 64'(e.op));
                            check("gpr_in", 64'(wr), 64'(e.wr));
                            check("lo_in", 64'(lo), 64'(e.lo));
                            check("hi_in", 64'(hi), 64'(e.hi));
                            check("latency", 64'(cyc), 64'(e.cycles));
                            check("t1w_cycles", 64'(waits), 64'(e.waits));
                            check("one_driver", 64'(bad), 64'd0);
                            pend = 1'b1; pend_v = e.cnt;
                            chk_b2b = run & step;
                        end
                        in_i = 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic wait_t0(output bit ok);
        int n;
        n = 0;
        while (pc_out !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        ok = (pc_out === 1'b1);
        if (!ok) begin
            tests++; fails++;
            $display("FAIL t0_timeout: pc_out=%0b after 60 cycles, expected 1", pc_out);
        end
    endtask

    // Wait for T0, present the instruction and hold mem_ready low for w cycles of T1/T1W.
    task automatic issue(input logic [31:0] instr, input int w);
        bit ok;
        exp_t e;
        logic [4:0] opc;
        logic md;
        wait_t0(ok);
        if (ok) begin
            opc    = instr[31:27];
            md     = (opc == 5'd8) || (opc == 5'd9);
            e.rd1  = 16'd1 << instr[22:19];
            e.rd2  = (opc == 5'd10 || opc == 5'd11) ? e.rd1 : (16'd1 << instr[18:15]);
            e.op   = opc[3:0];
            e.wr   = md ? 16'd0 : (16'd1 << instr[26:23]);
            e.lo   = md;
            e.hi   = md;
            e.cycles = (md ? 7 : 6) + w;
            e.waits  = w;
            exp_count = exp_count + 4'd1;
            e.cnt  = exp_count;
            sb.push_back(e);
            ir = instr;
            mem_ready = 1'b0;
            @(negedge clk);
            repeat (w) @(negedge clk);
            mem_ready = 1'b1;
        end
    endtask

    function automatic logic [31:0] rand_instr(input logic [4:0] opc);
        logic [3:0] a, b, c;
        logic [14:0] lowbits;
        a = 4'($urandom_range(0, 15));
        b = 4'($urandom_range(0, 15));
        c = 4'($urandom_range(0, 15));
        lowbits = 15'($urandom);
        return {opc, a, b, c, lowbits};
    endfunction

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("drain_left", 64'(sb.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic idle_check(input string name, input int n);
        bit seen;
        seen = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (ctl != 51'd0) seen = 1'b1;
        end
        check(name, 64'(seen), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin : driver
        bit ok;
        reset = 1'b1; run = 1'b0; mem_ready = 1'b0; step = 1'b1; ir = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_ctl", 64'(ctl), 64'd0);
        check("rst_illegal", 64'(illegal), 64'd0);
        check("rst_count", 64'(instr_count), 64'd0);
        reset = 1'b0;
        idle_check("idle_no_run", 4);

        // Directed: OR R5,R2,R4; MUL; OR with 3 waits; NEG; DIV with waits.
        run = 1'b1;
        issue(32'h0A920000, 0);
        issue(32'h42920000, 0);
        issue(32'h0A920000, 3);
        issue(rand_instr(5'd10), 1);
        issue(rand_instr(5'd9), 2);
        for (int i = 0; i < 40; i++)
            issue(rand_instr(5'($urandom_range(0, 11))), int'($urandom_range(0, 3)));
        run = 1'b0;  // last instruction must still complete
        drain();
        idle_check("idle_after_run", 8);

        // Reset in the middle of T4.
        run = 1'b1;
        wait_t0(ok);
        ir = 32'h0A920000; mem_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("t4_zin", 64'(z_in), 64'd1);
        check("t4_gpr_out", 64'(gpr_out), 64'h0010);
        reset = 1'b1; run = 1'b0;
        #1;
        check("midrst_ctl", 64'(ctl), 64'd0);
        check("midrst_illegal", 64'(illegal), 64'd0);
        check("midrst_count", 64'(instr_count), 64'd0);
        @(negedge clk);
        reset = 1'b0; sb.delete(); exp_count = 4'd0;
        idle_check("idle_after_rst", 5);

        // Illegal opcode: one good instruction, then opc 12..31.
        run = 1'b1;
        issue(32'h0A920000, 0);
        wait_t0(ok);
        ir = rand_instr(5'($urandom_range(12, 31))); mem_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("fault_illegal", 64'(illegal), 64'd1);
        check("fault_ctl", 64'(ctl), 64'd0);
        check("fault_count", 64'(instr_count), 64'(exp_count));
        idle_check("fault_hold", 10);
        check("fault_sticky", 64'(illegal), 64'd1);
        reset = 1'b1; run = 1'b0;
        @(negedge clk);
        reset = 1'b0; sb.delete(); exp_count = 4'd0;
        @(negedge clk);
        check("fault_cleared", 64'(illegal), 64'd0);

`ifdef ALU_SEQ_STEP_EN
        // Step mode: one instruction per step pulse.
        step = 1'b0; run = 1'b1;
        idle_check("step_wait", 4);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        issue(32'h0A920000, 0);
        drain();
        idle_check("step_idle_between", 12);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        issue(32'h42920000, 1);
        drain();
        idle_check("step_idle_after", 6);
        check("step_count", 64'(instr_count), 64'd2);
        run = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
